ram_copy_engine: RTL and testbench

Memory-side initiator for the single-port-pair simulation RAM. It accepts a copy command (source address, destination address, word count) and drives the RAM's read and write ports: one read, wait for read-valid, one write, per word. It is the requester end of the RAM read/write interface. Block-level benches use it to move data between RAM regions without the C testbench driving every access.

---
 rtl/ram_copy_engine.sv | 127 ++++++++++++
 tb/tb_ram_copy_engine.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: requester-side copy engine for the simulation RAM.
// It copies a block of words, one word at a time. For each word it issues a
// single-cycle read, waits for rd_valid, then issues a single-cycle write.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   cmd_valid / cmd_ready       command handshake; cmd_ready is high only when idle
//   cmd_src, cmd_dst, cmd_len   first source address, first destination address,
//                               and word count (0..2^ADDR_WIDTH)
//   busy, done, err, words_done status outputs
//   rd_en, rd_addr, rd_data, rd_valid   RAM read port
//   wr_en, wr_addr, wr_data             RAM write port
//
// Every output is either a register or a decode of the state register, so no
// input reaches an output within the same cycle.
module ram_copy_engine #(
  parameter int unsigned ADDR_WIDTH      = 6,
  parameter int unsigned DATA_SIZE_BYTES = 4,
  parameter int unsigned TIMEOUT         = 16,
  localparam int unsigned DATA_WIDTH     = DATA_SIZE_BYTES * 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StWrite,
    StFin
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic [ADDR_WIDTH:0]   words_done_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [CntWidth-1:0]   wait_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      remaining_q  <= '0;
      words_done_q <= '0;
      err_q        <= 1'b0;
      wr_data_q    <= '0;
      wait_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            src_q        <= cmd_src;
            dst_q        <= cmd_dst;
            remaining_q  <= cmd_len;
            err_q        <= 1'b0;
            words_done_q <= '0;
            state_q      <= (cmd_len == '0) ? StFin : StRead;
          end
        end
        StRead: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          // rd_valid only counts here; a stray one during StRead is ignored.
          if (rd_valid) begin
            wr_data_q <= rd_data;
            state_q   <= StWrite;
          end else if (wait_cnt_q == CntWidth'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= StFin;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntWidth'(1);
          end
        end
        StWrite: begin
          words_done_q <= words_done_q + (ADDR_WIDTH + 1)'(1);
          src_q        <= src_q + ADDR_WIDTH'(1);
          dst_q        <= dst_q + ADDR_WIDTH'(1);
          remaining_q  <= remaining_q - (ADDR_WIDTH + 1)'(1);
          state_q      <= (remaining_q == (ADDR_WIDTH + 1)'(1)) ? StFin : StRead;
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);
  assign rd_en      = (state_q == StRead);
  assign wr_en      = (state_q == StWrite);
  assign rd_addr    = src_q;
  assign wr_addr    = dst_q;
  assign wr_data    = wr_data_q;
  assign err        = err_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
module tb_ram_copy_engine;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_src;
  logic [5:0]  cmd_dst;
  logic [6:0]  cmd_len;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  words_done;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;

  ram_copy_engine #(
    .ADDR_WIDTH     (6),
    .DATA_SIZE_BYTES(4),
    .TIMEOUT        (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .words_done(words_done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  typedef struct {
    int         cyc;
    logic [6:0] words;
    logic       err;
  } done_t;

  logic [5:0]  rdq[$];
  logic [37:0] wrq[$];
  done_t       doneq[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // RAM model: read latency 1, response can be disabled for the timeout case.
  logic [31:0] mem[64];
  logic        init_mem;
  logic        ram_respond;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rd_valid <= rd_en && ram_respond;
    rd_data  <= mem[rd_addr];
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0]    <= 32'hA0A0A0A0;
      mem[1]    <= 32'hB1B1B1B1;
      mem[2]    <= 32'hC2C2C2C2;
      mem[3]    <= 32'hD3D3D3D3;
      mem[6'h3E] <= 32'h11111111;
      mem[6'h3F] <= 32'h22222222;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic note_fail(input string name, input logic [63:0] act);
    n_total++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read, write or done.
  always @(negedge clk) begin
    if (rd_en) begin
      if (rdq.size() == 0) note_fail("rd_unexpected", 64'(rd_addr));
      else chk("rd_addr", 64'(rd_addr), 64'(rdq.pop_front()));
    end
    if (wr_en) begin
      if (wrq.size() == 0) note_fail("wr_unexpected", 64'({wr_addr, wr_data}));
      else chk("wr_addr_data", 64'({wr_addr, wr_data}), 64'(wrq.pop_front()));
    end
    if (done) begin
      if (doneq.size() == 0) note_fail("done_unexpected", 64'(cyc));
      else begin
        done_t e;
        e = doneq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("done_words", 64'(words_done), 64'(e.words));
        chk("done_err", 64'(err), 64'(e.err));
      end
    end
  end

  task automatic check_reset();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_words_done", 64'(words_done), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
  endtask

  // Called at a negedge. acc is the cycle count seen at the negedge right
  // after the accepting edge; done is expected at acc + delay.
  task automatic send_cmd(input logic [5:0] s, input logic [5:0] d, input logic [6:0] l,
                          input int delay, input logic [6:0] ew, input logic ee,
                          input bit push_done, input bit hold, output int acc);
    int n;
    done_t e;
    cmd_valid = 1'b1;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_len   = l;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      note_fail("cmd_accept_timeout", 64'(n));
      acc = -1;
    end else begin
      acc = cyc + 1;
      if (push_done) begin
        e.cyc   = acc + delay;
        e.words = ew;
        e.err   = ee;
        doneq.push_back(e);
      end
    end
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((doneq.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n >= 200), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    rst_n       = 1'b0;
    init_mem    = 1'b1;
    ram_respond = 1'b1;
    cmd_valid   = 1'b0;
    cmd_src     = '0;
    cmd_dst     = '0;
    cmd_len     = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset();
    init_mem = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // 4-word copy, latency 1: done 3N = 12 edges after accept.
    for (int i = 0; i < 4; i++) rdq.push_back(6'(i));
    wrq.push_back({6'h20, 32'hA0A0A0A0});
    wrq.push_back({6'h21, 32'hB1B1B1B1});
    wrq.push_back({6'h22, 32'hC2C2C2C2});
    wrq.push_back({6'h23, 32'hD3D3D3D3});
    send_cmd(6'h00, 6'h20, 7'd4, 12, 7'd4, 1'b0, 1'b1, 1'b0, acc);
    drain();
    chk("mem_20", 64'(mem[6'h20]), 64'hA0A0A0A0);
    chk("mem_23", 64'(mem[6'h23]), 64'hD3D3D3D3);

    // len=0: done in the cycle right after accept, no RAM traffic.
    send_cmd(6'h05, 6'h06, 7'd0, 0, 7'd0, 1'b0, 1'b1, 1'b0, acc);
    drain();

    // Wrap with dst = src+1: every word re-reads the freshly written 0x11111111.
    rdq.push_back(6'h3E);
    rdq.push_back(6'h3F);
    rdq.push_back(6'h00);
    wrq.push_back({6'h3F, 32'h11111111});
    wrq.push_back({6'h00, 32'h11111111});
    wrq.push_back({6'h01, 32'h11111111});
    send_cmd(6'h3E, 6'h3F, 7'd3, 9, 7'd3, 1'b0, 1'b1, 1'b0, acc);
    drain();
    chk("mem_01", 64'(mem[6'h01]), 64'h11111111);

    // Timeout: one read, 16 WAIT cycles, no write.
    ram_respond = 1'b0;
    rdq.push_back(6'h10);
    send_cmd(6'h10, 6'h30, 7'd2, 17, 7'd0, 1'b1, 1'b1, 1'b0, acc);
    drain();
    repeat (3) @(negedge clk);
    chk("err_held", 64'(err), 64'd1);
    ram_respond = 1'b1;

    // Reset during the second WAIT of a 4-word copy.
    rdq.push_back(6'h20);
    rdq.push_back(6'h21);
    wrq.push_back({6'h28, 32'hA0A0A0A0});
    send_cmd(6'h20, 6'h28, 7'd4, 0, 7'd0, 1'b0, 1'b0, 1'b0, acc);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mem_28", 64'(mem[6'h28]), 64'hA0A0A0A0);
    chk("mem_29", 64'(mem[6'h29]), 64'h0);

    rdq.push_back(6'h22);
    rdq.push_back(6'h23);
    wrq.push_back({6'h2C, 32'hC2C2C2C2});
    wrq.push_back({6'h2D, 32'hD3D3D3D3});
    send_cmd(6'h22, 6'h2C, 7'd2, 6, 7'd2, 1'b0, 1'b1, 1'b0, acc);
    drain();

    // cmd_valid held through a busy 2-word copy with new args.
    rdq.push_back(6'h2C);
    rdq.push_back(6'h2D);
    rdq.push_back(6'h20);
    wrq.push_back({6'h34, 32'hC2C2C2C2});
    wrq.push_back({6'h35, 32'hD3D3D3D3});
    wrq.push_back({6'h38, 32'hA0A0A0A0});
    send_cmd(6'h2C, 6'h34, 7'd2, 6, 7'd2, 1'b0, 1'b1, 1'b1, acc);
    send_cmd(6'h20, 6'h38, 7'd1, 3, 7'd1, 1'b0, 1'b1, 1'b0, acc2);
    chk("second_accept_cycle", 64'(acc2), 64'(acc + 8));
    drain();
    chk("mem_38", 64'(mem[6'h38]), 64'hA0A0A0A0);

    repeat (3) @(negedge clk);
    chk("rdq_empty", 64'(rdq.size()), 64'd0);
    chk("wrq_empty", 64'(wrq.size()), 64'd0);
    chk("doneq_empty", 64'(doneq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
